// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : loader_pkg                                                       |
// | Brief   : Shared types and constants for the program loader.              |
// |           Macro LOADER_CHECKSUM_EN adds the CHK state.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package loader_pkg;

    localparam int         ADDR_W      = 12;
    localparam int         INSTR_W     = 19;
    localparam logic [7:0] LEN_HI_MASK = 8'hF0;
    localparam logic [7:0] B0_MASK     = 8'hF8;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LEN_HI = 4'd1,
        LEN_LO = 4'd2,
        B0     = 4'd3,
        B1     = 4'd4,
        B2     = 4'd5,
        WRITE  = 4'd6,
`ifdef LOADER_CHECKSUM_EN
        CHK    = 4'd7,
`endif
        DONE   = 4'd8,
        ERROR  = 4'd9
    } state_e;

endpackage
`default_nettype wire

// File: rtl/incrementer_12.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : incrementer_12                                                   |
// | Brief   : 12-bit combinational +1 used for the loader word counter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module incrementer_12 (
    input  logic [11:0] a_i,
    output logic [11:0] y_o
);

    assign y_o = a_i + 12'd1;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : program_loader                                                   |
// | Brief   : Streams a length-prefixed byte image into instruction memory,    |
// |           then releases the CPU. LOADER_CHECKSUM_EN adds an XOR trailer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module program_loader #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_data,
    output logic               cpu_run,
    output logic               done,
    output logic               error
);

    import loader_pkg::*;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e LOAD_END = CHK;
`else
    localparam state_e LOAD_END = DONE;
`endif

    state_e             state_q, state_d;
    logic [11:0]        len_q, len_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic               accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    incrementer_12 u_cnt_inc (
        .a_i (cnt_q),
        .y_o (cnt_inc)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            LEN_HI, LEN_LO, B0, B1, B2: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHK:                        in_ready = 1'b1;
`endif
            default:                    in_ready = 1'b0;
        endcase
    end

    assign accept = in_ready & in_valid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        if (accept && state_q != CHK) sum_d = sum_q ^ in_data;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LEN_HI;
                    cnt_d   = '0;
                    len_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LEN_HI: if (accept) begin
                len_d[11:8] = in_data[3:0];
                state_d     = ((in_data & LEN_HI_MASK) != 8'h00) ? ERROR : LEN_LO;
            end
            LEN_LO: if (accept) begin
                len_d[7:0] = in_data;
                state_d    = ({len_q[11:8], in_data} == 12'd0) ? LOAD_END : B0;
            end
            B0: if (accept) begin
                instr_d[INSTR_W-1:16] = in_data[2:0];
                state_d               = ((in_data & B0_MASK) != 8'h00) ? ERROR : B1;
            end
            B1: if (accept) begin
                instr_d[15:8] = in_data;
                state_d       = B2;
            end
            // Latch address and word on acceptance so WRITE presents them registered.
            B2: if (accept) begin
                addr_d  = cnt_q;
                data_d  = {instr_q[INSTR_W-1:8], in_data};
                state_d = WRITE;
            end
            WRITE: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == len_q) ? LOAD_END : B0;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: if (accept) begin
                state_d = (in_data == sum_q) ? DONE : ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign im_we   = (state_q == WRITE);
    assign im_addr = addr_q;
    assign im_data = data_q;
    assign done    = (state_q == DONE);
    assign error   = (state_q == ERROR);
    assign cpu_run = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_program_loader                                                |
// | Brief   : Directed self-checking bench for program_loader.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        im_we;
    logic [11:0] im_addr;
    logic [18:0] im_data;
    logic        cpu_run;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [11:0] wa[$];
    logic [18:0] wd[$];

    program_loader #(.ADDR_W(12), .INSTR_W(19)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .cpu_run  (cpu_run),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wa.push_back(im_addr);
            wd.push_back(im_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready got %0b want 1 for byte %02h", in_ready, b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Trailer byte is only part of the stream when the checksum build is used.
    task automatic finish_load(input logic [7:0] sum);
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum);
`else
        if (sum == 8'hxx) tick();
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        wa.delete();
        wd.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, im_we, im_addr, im_data, cpu_run, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {in_ready, im_we, im_addr, im_data, cpu_run, done, error});
        end
    endtask

    task automatic test_two_words();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h07); send_byte(8'hFF); send_byte(8'hFF);
        checks++;
        if (im_we !== 1'b1 || im_addr !== 12'd1 || im_data !== 19'h7FFFF) begin
            errors++;
            $display("FAIL two_words_write1: we/addr/data got %0b/%h/%h want 1/001/7ffff",
                     im_we, im_addr, im_data);
        end
        tick();
        finish_load(8'h04);
        checks++;
        if (done !== 1'b1 || cpu_run !== 1'b1 || error !== 1'b0 || im_we !== 1'b0) begin
            errors++;
            $display("FAIL two_words_done: done/run/err/we got %0b%0b%0b%0b want 1100",
                     done, cpu_run, error, im_we);
        end
        checks++;
        if (im_addr !== 12'd1 || im_data !== 19'h7FFFF) begin
            errors++;
            $display("FAIL two_words_hold: addr/data got %h/%h want 001/7ffff", im_addr, im_data);
        end
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL two_words_count: got %0d want 2", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 12'd0 || wd[0] !== 19'h00001 || wa[1] !== 12'd1 || wd[1] !== 19'h7FFFF) begin
                errors++;
                $display("FAIL two_words_log: got %h:%h %h:%h want 000:00001 001:7ffff",
                         wa[0], wd[0], wa[1], wd[1]);
            end
        end
    endtask

    task automatic test_len_hi_error();
        wa.delete(); wd.delete();
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_run !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_clears: done/run/ready got %0b%0b%0b want 001", done, cpu_run, in_ready);
        end
        send_byte(8'h10);
        tick();
        checks++;
        if (error !== 1'b1 || cpu_run !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len_hi_error: err/run/done/ready got %0b%0b%0b%0b want 1000",
                     error, cpu_run, done, in_ready);
        end
        checks++;
        if (wa.size() != 0) begin
            errors++;
            $display("FAIL len_hi_nowrite: got %0d writes want 0", wa.size());
        end
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_cleared: got %0b want 0", error);
        end
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h08);
        checks++;
        if (error !== 1'b1 || wa.size() != 0) begin
            errors++;
            $display("FAIL b0_error: err got %0b writes %0d want 1 and 0", error, wa.size());
        end
    endtask

    task automatic test_stall();
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h05); send_byte(8'hA5);
        in_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || im_we !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d ready/we/done got %0b%0b%0b want 100",
                         i, in_ready, im_we, done);
            end
        end
        send_byte(8'h3C);
        tick();
        finish_load(8'h9D);
        checks++;
        if (wa.size() != 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_count: writes %0d done %0b want 1 and 1", wa.size(), done);
        end else begin
            checks++;
            if (wa[0] !== 12'd0 || wd[0] !== 19'h5A53C) begin
                errors++;
                $display("FAIL stall_write: got %h:%h want 000:5a53c", wa[0], wd[0]);
            end
        end
    endtask

    task automatic test_reset_midload();
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h05);
        for (int w = 1; w <= 3; w++) begin
            send_byte(8'h00); send_byte(8'h00); send_byte(8'(w));
        end
        send_byte(8'h00);
        in_valid = 1'b1;
        in_data  = 8'h11;
        rst      = 1'b0;
        tick();
        checks++;
        if ({in_ready, im_we, im_addr, im_data, cpu_run, done, error} !== '0) begin
            errors++;
            $display("FAIL midload_reset: got %h want 0",
                     {in_ready, im_we, im_addr, im_data, cpu_run, done, error});
        end
        rst = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (wa.size() != 3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midload_writes: writes %0d ready %0b want 3 and 0", wa.size(), in_ready);
        end
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h42);
        tick();
        finish_load(8'h43);
        checks++;
        if (wa.size() != 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL reload_count: writes %0d done %0b want 1 and 1", wa.size(), done);
        end else begin
            checks++;
            if (wa[0] !== 12'd0 || wd[0] !== 19'h00042) begin
                errors++;
                $display("FAIL reload_write: got %h:%h want 000:00042", wa[0], wd[0]);
            end
        end
    endtask

    task automatic test_len_zero();
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        finish_load(8'h00);
        checks++;
        if (done !== 1'b1 || cpu_run !== 1'b1 || wa.size() != 0) begin
            errors++;
            $display("FAIL len_zero: done/run got %0b%0b writes %0d want 11 and 0",
                     done, cpu_run, wa.size());
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            wa.delete(); wd.delete();
            pulse_start();
            send_byte(8'h00); send_byte(8'h01);
            send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
            send_byte(k == 0 ? 8'h66 : 8'h67);
            checks++;
            if (done !== (k == 0) || error !== (k == 1) || wa.size() != 1) begin
                errors++;
                $display("FAIL checksum_%0d: done/err got %0b%0b writes %0d", k, done, error, wa.size());
            end else begin
                checks++;
                if (wd[0] !== 19'h12345) begin
                    errors++;
                    $display("FAIL checksum_word: got %h want 12345", wd[0]);
                end
            end
        end
    endtask
`endif

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        test_reset();
        test_two_words();
        test_len_hi_error();
        test_stall();
        test_reset_midload();
        test_len_zero();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
